// File: rtl/fixed_to_float_pipe.sv
// Three-stage converter from the unsigned fixed-point CORDIC x-output to IEEE-754 single.
// Stages: capture + leading-one detect, normalise + exponent, round/pack.

module pri_enc32 (
  input  logic [31:0] in_vec,
  output logic [4:0]  idx,
  output logic        valid
);
  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    idx   = 5'd0;
    valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (in_vec[i]) begin
        idx   = 5'(i);
        valid = 1'b1;
      end
    end
  end
endmodule

module fixed_to_float_pipe #(
  parameter int IN_WIDTH  = 21,
  parameter int FRAC_BITS = 20
) (
  input  logic                clock,
  input  logic                aclr,
  input  logic                clk_en,
  input  logic                valid_in,
  input  logic [IN_WIDTH-1:0] fixed_in,
  output logic [31:0]         result,
  output logic                valid_out
);
  localparam int         SRC_W    = IN_WIDTH - 1;
  localparam logic [8:0] EXP_BASE = 9'(127 - FRAC_BITS);

  logic [IN_WIDTH-1:0] s1_data;
  logic                s1_valid;
  logic [4:0]          lead_idx;
  logic                lead_found;
  logic [5:0]          shamt;

  logic [SRC_W-1:0]    s2_src;
  logic [7:0]          s2_exp;
  logic                s2_zero;
  logic                s2_valid;

  logic [22:0]         mant;
  logic                carry;

  always_ff @(posedge clock) begin
    if (aclr) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else if (clk_en) begin
      s1_data  <= fixed_in;
      s1_valid <= valid_in;
    end
  end

  pri_enc32 u_lead_one (
    .in_vec (32'(s1_data)),
    .idx    (lead_idx),
    .valid  (lead_found)
  );

  assign shamt = 6'(SRC_W) - 6'(lead_idx);

  // The shift parks the leading one at bit IN_WIDTH-1; the cast drops it (implicit one).
  always_ff @(posedge clock) begin
    if (aclr) begin
      s2_src   <= '0;
      s2_exp   <= '0;
      s2_zero  <= 1'b0;
      s2_valid <= 1'b0;
    end else if (clk_en) begin
      s2_src   <= SRC_W'(s1_data << shamt);
      s2_exp   <= 8'(EXP_BASE + 9'(lead_idx));
      s2_zero  <= ~lead_found;
      s2_valid <= s1_valid;
    end
  end

  generate
    if (SRC_W <= 23) begin : g_exact
      assign mant  = 23'(s2_src) << (23 - SRC_W);
      assign carry = 1'b0;
    end else begin : g_round
      logic [22:0] keep;
      logic        guard;
      logic        sticky;
      logic        round_up;
      logic [23:0] sum;

      assign keep  = s2_src[SRC_W-1 -: 23];
      assign guard = s2_src[SRC_W-24];
      if (SRC_W > 24) begin : g_sticky
        assign sticky = |s2_src[SRC_W-25:0];
      end else begin : g_no_sticky
        assign sticky = 1'b0;
      end
      // Nearest-even: round up above half, or at exactly half when the kept LSB is odd.
      assign round_up = guard & (sticky | keep[0]);
      assign sum      = {1'b0, keep} + {23'd0, round_up};
      assign mant     = sum[22:0];
      assign carry    = sum[23];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (aclr) begin
      result    <= 32'h0;
      valid_out <= 1'b0;
    end else if (clk_en) begin
      result    <= s2_zero ? 32'h0 : {1'b0, s2_exp + 8'(carry), mant};
      valid_out <= s2_valid;
    end
  end
endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Bench for fixed_to_float_pipe: default 21/20 lane and a 32/20 lane exercising rounding,
// both fed the same control stream and scored against a queue of expected outputs.

module tb_fixed_to_float_pipe;
  logic        clock = 1'b0;
  logic        aclr;
  logic        clk_en;
  logic        valid_in;
  logic [20:0] fixed_a;
  logic [31:0] fixed_b;
  logic [31:0] result_a, result_b;
  logic        valid_out_a, valid_out_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        v;
    logic        chk;
    logic [31:0] ra;
    logic [31:0] rb;
  } exp_t;

  localparam exp_t ZERO_E = {1'b0, 1'b1, 32'h0, 32'h0};

  exp_t sb[$];
  exp_t held;

  always #5 clock = ~clock;

  fixed_to_float_pipe dut_a (
    .clock     (clock),
    .aclr      (aclr),
    .clk_en    (clk_en),
    .valid_in  (valid_in),
    .fixed_in  (fixed_a),
    .result    (result_a),
    .valid_out (valid_out_a)
  );

  fixed_to_float_pipe #(.IN_WIDTH(32), .FRAC_BITS(20)) dut_b (
    .clock     (clock),
    .aclr      (aclr),
    .clk_en    (clk_en),
    .valid_in  (valid_in),
    .fixed_in  (fixed_b),
    .result    (result_b),
    .valid_out (valid_out_b)
  );

  // Reference conversion: exact 64-bit alignment, then round-nearest-even on the dropped bits.
  function automatic logic [31:0] model(input logic [31:0] x, input int fb);
    int          p;
    int          e;
    logic [63:0] m;
    logic [22:0] man;
    logic [39:0] rem;
    if (x == 32'h0) return 32'h0;
    p = 0;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    m   = {32'h0, x} << (63 - p);
    man = m[62:40];
    rem = m[39:0];
    e   = 127 + p - fb;
    if (rem > 40'h80_0000_0000 || (rem == 40'h80_0000_0000 && man[0])) begin
      if (man == 23'h7FFFFF) begin
        man = 23'h0;
        e   = e + 1;
      end else begin
        man = man + 23'd1;
      end
    end
    return {1'b0, 8'(e), man};
  endfunction

  // Drives one edge and returns the output expected just after it.
  task automatic drive_edge(input logic en, input logic rst, input logic v,
                            input logic [20:0] xa, input logic [31:0] ea,
                            input logic [31:0] xb, input logic [31:0] eb,
                            output exp_t ex);
    clk_en   = en;
    aclr     = rst;
    valid_in = v;
    fixed_a  = xa;
    fixed_b  = xb;
    @(posedge clock);
    #1;
    if (rst) begin
      sb.delete();
      sb.push_back(ZERO_E);
      sb.push_back(ZERO_E);
      held = ZERO_E;
    end else if (en) begin
      sb.push_back({v, v, ea, eb});
      held = sb.pop_front();
    end
    ex = held;
  endtask

  task automatic test_reset();
    exp_t ex;
    drive_edge(1'b0, 1'b1, 1'b1, 21'h100000, 32'h0, 32'h00100000, 32'h0, ex);
    checks++; if (valid_out_a !== 1'b0) begin errors++; $display("FAIL reset valid_a: got %b want 0", valid_out_a); end
    checks++; if (valid_out_b !== 1'b0) begin errors++; $display("FAIL reset valid_b: got %b want 0", valid_out_b); end
    checks++; if (result_a !== 32'h0) begin errors++; $display("FAIL reset result_a: got %h want 00000000", result_a); end
    checks++; if (result_b !== 32'h0) begin errors++; $display("FAIL reset result_b: got %h want 00000000", result_b); end
  endtask

  task automatic test_vectors();
    logic [20:0] xa [6] = '{21'h100000, 21'h080000, 21'h000000, 21'h1FFFFF, 21'h000001, 21'h08A51C};
    logic [31:0] ea [6] = '{32'h3F800000, 32'h3F000000, 32'h00000000, 32'h3FFFFFF8, 32'h35800000, 32'h3F0A51C0};
    logic [31:0] xb [6] = '{32'hFFFFFFFF, 32'h01000001, 32'h01000003, 32'h00100000, 32'h00000000, 32'h00000001};
    logic [31:0] eb [6] = '{32'h45800000, 32'h41800000, 32'h41800002, 32'h3F800000, 32'h00000000, 32'h35800000};
    exp_t ex;
    drive_edge(1'b1, 1'b1, 1'b0, 21'h0, 32'h0, 32'h0, 32'h0, ex);
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive_edge(1'b1, 1'b0, 1'b1, xa[i], ea[i], xb[i], eb[i], ex);
      else       drive_edge(1'b1, 1'b0, 1'b0, 21'h0, 32'h0, 32'h0, 32'h0, ex);
      checks++; if (valid_out_a !== ex.v) begin errors++; $display("FAIL vectors valid_a cyc %0d: got %b want %b", i, valid_out_a, ex.v); end
      checks++; if (valid_out_b !== ex.v) begin errors++; $display("FAIL vectors valid_b cyc %0d: got %b want %b", i, valid_out_b, ex.v); end
      if (ex.chk) begin
        checks++; if (result_a !== ex.ra) begin errors++; $display("FAIL vectors result_a cyc %0d: got %h want %h", i, result_a, ex.ra); end
        checks++; if (result_b !== ex.rb) begin errors++; $display("FAIL vectors result_b cyc %0d: got %h want %h", i, result_b, ex.rb); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        ex;
    logic [20:0] xa;
    logic [31:0] xb;
    int          first = -1;
    int          last  = -1;
    int          count = 0;
    drive_edge(1'b1, 1'b1, 1'b0, 21'h0, 32'h0, 32'h0, 32'h0, ex);
    for (int i = 0; i < 14; i++) begin
      xa = 21'($urandom);
      xb = $urandom >> $urandom_range(0, 24);
      if (i < 11) drive_edge(1'b1, 1'b0, 1'b1, xa, model(32'(xa), 20), xb, model(xb, 20), ex);
      else        drive_edge(1'b1, 1'b0, 1'b0, 21'h0, 32'h0, 32'h0, 32'h0, ex);
      if (valid_out_a === 1'b1) begin
        if (first < 0) first = i;
        last  = i;
        count = count + 1;
      end
      checks++; if (valid_out_a !== ex.v) begin errors++; $display("FAIL b2b valid_a cyc %0d: got %b want %b", i, valid_out_a, ex.v); end
      checks++; if (valid_out_b !== ex.v) begin errors++; $display("FAIL b2b valid_b cyc %0d: got %b want %b", i, valid_out_b, ex.v); end
      if (ex.chk) begin
        checks++; if (result_a !== ex.ra) begin errors++; $display("FAIL b2b result_a cyc %0d: got %h want %h", i, result_a, ex.ra); end
        checks++; if (result_b !== ex.rb) begin errors++; $display("FAIL b2b result_b cyc %0d: got %h want %h", i, result_b, ex.rb); end
      end
    end
    checks++; if (first !== 2) begin errors++; $display("FAIL b2b first_valid: got edge %0d want edge 2", first); end
    checks++; if (count !== 11) begin errors++; $display("FAIL b2b valid_count: got %0d want 11", count); end
    checks++; if (last - first + 1 !== 11) begin errors++; $display("FAIL b2b contiguous_span: got %0d want 11", last - first + 1); end
  endtask

  task automatic test_stall_bubble();
    logic en_t [14] = '{1,1,1,1,0,0,1,1,1,1,1,1,1,1};
    logic v_t  [14] = '{1,1,1,0,1,1,1,1,0,0,0,0,0,0};
    exp_t        ex;
    logic [20:0] xa;
    logic [31:0] xb;
    int          accepted = 0;
    int          emitted  = 0;
    drive_edge(1'b1, 1'b1, 1'b0, 21'h0, 32'h0, 32'h0, 32'h0, ex);
    for (int i = 0; i < 14; i++) begin
      xa = 21'($urandom);
      xb = $urandom;
      if (en_t[i] && v_t[i]) accepted = accepted + 1;
      drive_edge(en_t[i], 1'b0, v_t[i], xa, model(32'(xa), 20), xb, model(xb, 20), ex);
      if (en_t[i] && valid_out_a === 1'b1) emitted = emitted + 1;
      checks++; if (valid_out_a !== ex.v) begin errors++; $display("FAIL stall valid_a cyc %0d: got %b want %b", i, valid_out_a, ex.v); end
      checks++; if (valid_out_b !== ex.v) begin errors++; $display("FAIL stall valid_b cyc %0d: got %b want %b", i, valid_out_b, ex.v); end
      if (ex.chk) begin
        checks++; if (result_a !== ex.ra) begin errors++; $display("FAIL stall result_a cyc %0d: got %h want %h", i, result_a, ex.ra); end
        checks++; if (result_b !== ex.rb) begin errors++; $display("FAIL stall result_b cyc %0d: got %h want %h", i, result_b, ex.rb); end
      end
    end
    checks++; if (emitted !== accepted) begin errors++; $display("FAIL stall emitted_count: got %0d want %0d", emitted, accepted); end
  endtask

  task automatic test_reset_midop();
    exp_t ex;
    int   seen = 0;
    drive_edge(1'b1, 1'b1, 1'b0, 21'h0, 32'h0, 32'h0, 32'h0, ex);
    drive_edge(1'b1, 1'b0, 1'b1, 21'h100000, 32'h3F800000, 32'h00100000, 32'h3F800000, ex);
    drive_edge(1'b1, 1'b0, 1'b1, 21'h080000, 32'h3F000000, 32'h00080000, 32'h3F000000, ex);
    drive_edge(1'b1, 1'b1, 1'b1, 21'h1FFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, ex);
    checks++; if (valid_out_a !== 1'b0) begin errors++; $display("FAIL midrst valid_a: got %b want 0", valid_out_a); end
    checks++; if (result_a !== 32'h0) begin errors++; $display("FAIL midrst result_a: got %h want 00000000", result_a); end
    checks++; if (result_b !== 32'h0) begin errors++; $display("FAIL midrst result_b: got %h want 00000000", result_b); end
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive_edge(1'b1, 1'b0, 1'b1, 21'h08A51C, 32'h3F0A51C0, 32'h01000003, 32'h41800002, ex);
      else        drive_edge(1'b1, 1'b0, 1'b0, 21'h0, 32'h0, 32'h0, 32'h0, ex);
      if (valid_out_a === 1'b1) seen = seen + 1;
      checks++; if (valid_out_a !== ex.v) begin errors++; $display("FAIL midrst valid_a cyc %0d: got %b want %b", i, valid_out_a, ex.v); end
      checks++; if (valid_out_b !== ex.v) begin errors++; $display("FAIL midrst valid_b cyc %0d: got %b want %b", i, valid_out_b, ex.v); end
      if (ex.chk) begin
        checks++; if (result_a !== ex.ra) begin errors++; $display("FAIL midrst result_a cyc %0d: got %h want %h", i, result_a, ex.ra); end
        checks++; if (result_b !== ex.rb) begin errors++; $display("FAIL midrst result_b cyc %0d: got %h want %h", i, result_b, ex.rb); end
      end
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL midrst emitted_count: got %0d want 1", seen); end
  endtask

  initial begin
    aclr     = 1'b1;
    clk_en   = 1'b0;
    valid_in = 1'b0;
    fixed_a  = '0;
    fixed_b  = '0;
    held     = ZERO_E;
    @(posedge clock);
    #1;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall_bubble();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
